// File: rtl/perf_monitor_if.sv
// Bus between the core-side controller and the performance monitor:
// window control, retire/event strobes, counter readout and status.
interface perf_monitor_if #(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 4
);
  localparam int SEL_W = $clog2(NUM_EVT + 2);

  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   instr_target;
  logic               retire_valid;
  logic [NUM_EVT-1:0] evt;
  logic [SEL_W-1:0]   rd_sel;
  logic [CNT_W-1:0]   rd_data;
  logic               running;
  logic               done;
  logic               timeout;
  logic               overflow;

  modport master (
    output start, stop, instr_target, retire_valid, evt, rd_sel,
    input  rd_data, running, done, timeout, overflow
  );

  modport slave (
    input  start, stop, instr_target, retire_valid, evt, rd_sel,
    output rd_data, running, done, timeout, overflow
  );
endinterface

// File: rtl/perf_monitor.sv
// Performance monitor: saturating cycle/retire/event counters over one
// measurement window, ended by stop, an instruction target or a watchdog.
module perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int NUM_EVT     = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic         clk,
  input  logic         reset,
  perf_monitor_if.slave bus
);
  localparam int NUM_CNT = NUM_EVT + 2;
  localparam int SEL_W   = $clog2(NUM_CNT);
  localparam int CMP_W   = ((CNT_W > 32) ? CNT_W : 32) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q   [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d   [NUM_CNT];
  logic [CNT_W-1:0]   cnt_inc [NUM_CNT];
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_CNT-1:0] inc_req;
  logic               sat_hit;
  logic               target_hit;
  logic               tmo_hit;

  // Counter 0 = cycles, 1 = retired, 2+k = event k; saturate at all-ones.
  always_comb begin
    inc_req = {bus.evt, bus.retire_valid, 1'b1};
    sat_hit = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (inc_req[i]) begin
        if (cnt_q[i] == CNT_MAX) sat_hit = 1'b1;
        else                     cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    target_hit = (bus.instr_target != '0) && (cnt_inc[1] >= bus.instr_target);
    tmo_hit    = (TIMEOUT_CYC != 0) &&
                 (CMP_W'(cnt_inc[0]) >= CMP_W'($unsigned(TIMEOUT_CYC)));
  end

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = cnt_q[i];

    if (bus.start) begin
      state_d    = RUN;
      overflow_d = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
    end else if (state_q == RUN) begin
      // Terminating edge keeps its increments; stop beats target beats watchdog.
      for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = cnt_inc[i];
      overflow_d = overflow_q | sat_hit;
      if (bus.stop)      state_d = DONE;
      else if (target_hit) state_d = DONE;
      else if (tmo_hit)    state_d = TMO;
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus.rd_sel == SEL_W'(i)) rd_data_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.timeout  = (state_q == TMO);
  assign bus.overflow = overflow_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit/200-cycle-watchdog instance and a 4-bit
// no-watchdog instance share one stimulus stream and are checked against a model.
module tb_perf_monitor;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  perf_monitor_if #(.CNT_W(32), .NUM_EVT(4)) bus_a ();
  perf_monitor_if #(.CNT_W(4),  .NUM_EVT(4)) bus_b ();

  perf_monitor #(.CNT_W(32), .NUM_EVT(4), .TIMEOUT_CYC(200)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  perf_monitor #(.CNT_W(4), .NUM_EVT(4), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Reference model: phase 0 idle, 1 run, 2 done, 3 timed out.
  longint unsigned m_cnt [2][6];
  int              m_phase [2];
  bit              m_ovf [2];
  longint unsigned m_rd [2];
  longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'hF};
  longint unsigned m_tmo [2] = '{200, 0};

  int vectors     = 0;
  int miscompares = 0;

  function automatic void modelStep(input int d, input bit rst, input bit s,
                                    input bit p, input bit rv, input logic [3:0] e,
                                    input longint unsigned tgt, input int sel);
    bit hit;
    m_rd[d] = (sel < 6) ? m_cnt[d][sel] : 0;
    if (rst) begin
      m_phase[d] = 0;
      m_ovf[d]   = 1'b0;
      m_rd[d]    = 0;
      for (int k = 0; k < 6; k++) m_cnt[d][k] = 0;
    end else if (s) begin
      m_phase[d] = 1;
      m_ovf[d]   = 1'b0;
      for (int k = 0; k < 6; k++) m_cnt[d][k] = 0;
    end else if (m_phase[d] == 1) begin
      for (int k = 0; k < 6; k++) begin
        hit = (k == 0) ? 1'b1 : (k == 1) ? rv : e[k-2];
        if (hit) begin
          if (m_cnt[d][k] == m_max[d]) m_ovf[d] = 1'b1;
          else                         m_cnt[d][k] = m_cnt[d][k] + 1;
        end
      end
      if (p)                                          m_phase[d] = 2;
      else if (tgt != 0 && m_cnt[d][1] >= tgt)        m_phase[d] = 2;
      else if (m_tmo[d] != 0 && m_cnt[d][0] >= m_tmo[d]) m_phase[d] = 3;
    end
  endfunction

  task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic checkOutput(input string tag);
    checkOne({tag, "/a.running"},  64'(bus_a.running),  64'(m_phase[0] == 1));
    checkOne({tag, "/a.done"},     64'(bus_a.done),     64'(m_phase[0] == 2));
    checkOne({tag, "/a.timeout"},  64'(bus_a.timeout),  64'(m_phase[0] == 3));
    checkOne({tag, "/a.overflow"}, 64'(bus_a.overflow), 64'(m_ovf[0]));
    checkOne({tag, "/a.rd_data"},  64'(bus_a.rd_data),  m_rd[0]);
    checkOne({tag, "/b.running"},  64'(bus_b.running),  64'(m_phase[1] == 1));
    checkOne({tag, "/b.done"},     64'(bus_b.done),     64'(m_phase[1] == 2));
    checkOne({tag, "/b.timeout"},  64'(bus_b.timeout),  64'(m_phase[1] == 3));
    checkOne({tag, "/b.overflow"}, 64'(bus_b.overflow), 64'(m_ovf[1]));
    checkOne({tag, "/b.rd_data"},  64'(bus_b.rd_data),  m_rd[1]);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic applyStimulus(input bit rst, input bit s, input bit p, input bit rv,
                               input logic [3:0] e, input int unsigned tgt,
                               input int sel, input string tag);
    reset              = rst;
    bus_a.start        = s;
    bus_b.start        = s;
    bus_a.stop         = p;
    bus_b.stop         = p;
    bus_a.retire_valid = rv;
    bus_b.retire_valid = rv;
    bus_a.evt          = e;
    bus_b.evt          = e;
    bus_a.instr_target = tgt;
    bus_b.instr_target = 4'(tgt);
    bus_a.rd_sel       = 3'(sel);
    bus_b.rd_sel       = 3'(sel);
    @(posedge clk);
    modelStep(0, rst, s, p, rv, e, longint'(tgt), sel);
    modelStep(1, rst, s, p, rv, e, longint'(tgt & 15), sel);
    #1;
    checkOutput(tag);
  endtask

  task automatic readBack(input int sel);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, sel, "readback");
  endtask

  initial begin
    // Reset, then sweep every read select (including out-of-range) while idle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, "t1.reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, "t1.reset");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 0, i, "t1.idle");

    // Target of 8 with a retire every cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8, 0, "t2.start");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom), 8, $urandom_range(0, 7), "t2.run");
    checkOne("t2.done_a", 64'(bus_a.done), 64'd1);
    readBack(0);
    checkOne("t2.cycles_a", 64'(bus_a.rd_data), 64'd8);
    readBack(1);
    checkOne("t2.retired_a", 64'(bus_a.rd_data), 64'd8);

    // Retire on odd run cycles, evt0 on even ones.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8, 0, "t3.start");
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, (i % 2) == 0, ((i % 2) == 1) ? 4'h1 : 4'h0,
                    8, $urandom_range(0, 7), "t3.run");
    checkOne("t3.done_b", 64'(bus_b.done), 64'd1);
    readBack(0);
    checkOne("t3.cycles_b", 64'(bus_b.rd_data), 64'd15);
    readBack(1);
    checkOne("t3.retired_a", 64'(bus_a.rd_data), 64'd8);
    readBack(2);
    checkOne("t3.evt0_a", 64'(bus_a.rd_data), 64'd7);
    checkOne("t3.ovf_b", 64'(bus_b.overflow), 64'd0);

    // No target, no retires: the 200-cycle watchdog fires on instance a.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, "t4.start");
    for (int i = 0; i < 200; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom), 0, $urandom_range(0, 7), "t4.run");
    checkOne("t4.timeout_a", 64'(bus_a.timeout), 64'd1);
    checkOne("t4.done_a", 64'(bus_a.done), 64'd0);
    readBack(0);
    checkOne("t4.cycles_a", 64'(bus_a.rd_data), 64'd200);

    // Saturation of the 4-bit instance, then restart clears everything.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1, "t5.start");
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 1, "t5.run");
    checkOne("t5.ovf_pre_b", 64'(bus_b.overflow), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 1, "t5.run16");
    checkOne("t5.ovf_b", 64'(bus_b.overflow), 64'd1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom), 0, 1, "t5.sat");
    readBack(1);
    checkOne("t5.retired_b", 64'(bus_b.rd_data), 64'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1, "t5.restart");
    checkOne("t5.ovf_clr_b", 64'(bus_b.overflow), 64'd0);
    readBack(1);
    checkOne("t5.retired_clr_b", 64'(bus_b.rd_data), 64'd0);

    // Stop and target on the same edge, reset mid-run, start mid-run.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 5, 0, "t6.start");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5, 0, "t6.run");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 5, 0, "t6.stop_tgt");
    checkOne("t6.done_a", 64'(bus_a.done), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, "t6.start2");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom), 0, 0, "t6.run2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 0, 0, "t6.reset");
    checkOne("t6.running_rst_a", 64'(bus_a.running), 64'd0);
    readBack(0);
    checkOne("t6.cycles_rst_a", 64'(bus_a.rd_data), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, "t6.start3");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom), 0, 0, "t6.run3");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 0, 0, "t6.restart");
    checkOne("t6.running_a", 64'(bus_a.running), 64'd1);
    readBack(0);
    checkOne("t6.cycles_restart_a", 64'(bus_a.rd_data), 64'd0);

    // Random traffic with occasional start/stop/reset.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom),
                    $urandom_range(0, 15), $urandom_range(0, 7), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
